// File: rtl/done_alarm.sv
// End-of-cook alert: turns a timer_done rising edge into NUM_BEEPS gated tone bursts,
// then holds a "food ready" indicator until the door opens or clear is pressed.
module done_alarm #(
    parameter int BEEP_ON_CYCLES  = 500,
    parameter int BEEP_OFF_CYCLES = 500,
    parameter int NUM_BEEPS       = 3,
    parameter int TONE_HALF       = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic timer_done,
    input  logic door_closed,
    input  logic clearn,
    output logic buzzer,
    output logic beep_active,
    output logic done_led,
    output logic alarm_busy
);

    localparam int MAX_PHASE = (BEEP_ON_CYCLES > BEEP_OFF_CYCLES) ? BEEP_ON_CYCLES : BEEP_OFF_CYCLES;
    localparam int PHASE_W   = $clog2(MAX_PHASE + 1);
    localparam int TONE_W    = $clog2(TONE_HALF + 1);

    typedef enum logic [1:0] {
        IDLE,
        BEEP_ON,
        BEEP_OFF,
        LATCHED
    } state_t;

    state_t              state, state_n;
    logic [PHASE_W-1:0]  phase, phase_n;
    logic [3:0]          beep, beep_n;
    logic [TONE_W-1:0]   tone, tone_n;
    logic                td_q;
    logic                tone_wrap;
    logic                buzzer_d, beep_active_d, done_led_d, alarm_busy_d;

    logic start, ack;
    assign start = timer_done & ~td_q;
    assign ack   = ~door_closed | ~clearn;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // td_q tracks the input even in reset: a level already high at release is not a new edge.
        td_q <= timer_done;
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            beep        <= '0;
            tone        <= '0;
            buzzer      <= 1'b0;
            beep_active <= 1'b0;
            done_led    <= 1'b0;
            alarm_busy  <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            beep        <= beep_n;
            tone        <= tone_n;
            buzzer      <= buzzer_d;
            beep_active <= beep_active_d;
            done_led    <= done_led_d;
            alarm_busy  <= alarm_busy_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        beep_n    = beep;
        tone_n    = tone;
        tone_wrap = 1'b0;

        case (state)
            IDLE: begin
                phase_n = '0;
                beep_n  = '0;
                tone_n  = '0;
                if (start) begin
                    state_n = BEEP_ON;
                    beep_n  = 4'd1;
                end
            end
            BEEP_ON: begin
                if (phase == PHASE_W'(BEEP_ON_CYCLES - 1)) begin
                    state_n = BEEP_OFF;
                    phase_n = '0;
                    tone_n  = '0;
                end else begin
                    phase_n = phase + PHASE_W'(1);
                    if (tone == TONE_W'(TONE_HALF - 1)) begin
                        tone_n    = '0;
                        tone_wrap = 1'b1;
                    end else begin
                        tone_n = tone + TONE_W'(1);
                    end
                end
            end
            BEEP_OFF: begin
                if (phase == PHASE_W'(BEEP_OFF_CYCLES - 1)) begin
                    phase_n = '0;
                    tone_n  = '0;
                    if (beep == 4'(NUM_BEEPS)) begin
                        state_n = LATCHED;
                    end else begin
                        state_n = BEEP_ON;
                        beep_n  = beep + 4'd1;
                    end
                end else begin
                    phase_n = phase + PHASE_W'(1);
                end
            end
            LATCHED: ;
            default: state_n = IDLE;
        endcase

        // Acknowledge beats both a new start and any counter expiry.
        if (ack) begin
            state_n = IDLE;
            phase_n = '0;
            beep_n  = '0;
            tone_n  = '0;
        end
    end

    // Outputs are decoded from the next state and registered, so no input reaches them combinationally.
    always_comb begin
        beep_active_d = (state_n == BEEP_ON);
        alarm_busy_d  = (state_n == BEEP_ON) || (state_n == BEEP_OFF);
        done_led_d    = (state_n != IDLE);
        buzzer_d      = 1'b0;
        if (state_n == BEEP_ON) begin
            if (state != BEEP_ON)
                buzzer_d = 1'b1;
            else if (tone_wrap)
                buzzer_d = ~buzzer;
            else
                buzzer_d = buzzer;
        end
    end

endmodule

// File: tb/tb_done_alarm.sv
// Randomized and directed checks of done_alarm against a cycle-count model of the alert.
module tb_done_alarm;

    localparam int ON_C   = 4;
    localparam int OFF_C  = 3;
    localparam int NBEEP  = 3;
    localparam int THALF  = 1;
    localparam int PERIOD = ON_C + OFF_C;
    localparam int TOTAL  = NBEEP * PERIOD;

    logic clk = 1'b0;
    logic reset, timer_done, door_closed, clearn;
    logic buzzer, beep_active, done_led, alarm_busy;

    int vectors = 0;
    int miscompares = 0;

    // Model: whether an alert is in progress and how many cycles since it began.
    bit m_alert = 1'b0;
    int m_t = 0;
    bit m_prev = 1'b0;

    done_alarm #(
        .BEEP_ON_CYCLES (ON_C),
        .BEEP_OFF_CYCLES(OFF_C),
        .NUM_BEEPS      (NBEEP),
        .TONE_HALF      (THALF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .timer_done (timer_done),
        .door_closed(door_closed),
        .clearn     (clearn),
        .buzzer     (buzzer),
        .beep_active(beep_active),
        .done_led   (done_led),
        .alarm_busy (alarm_busy)
    );

    always #5 clk = ~clk;

    // Expected {buzzer, beep_active, done_led, alarm_busy}.
    function automatic logic [3:0] exp_vec();
        logic on;
        if (!m_alert) return 4'b0000;
        if (m_t >= TOTAL) return 4'b0010;
        on = (m_t % PERIOD) < ON_C;
        return {on && (((m_t % PERIOD) / THALF) % 2 == 0), on, 1'b1, 1'b1};
    endfunction

    function automatic logic [3:0] obs_vec();
        return {buzzer, beep_active, done_led, alarm_busy};
    endfunction

    // Advance one clock, update the model from the inputs the DUT saw, sample 1 time unit later.
    task automatic tick();
        bit ack, start;
        @(posedge clk);
        ack   = !door_closed || !clearn;
        start = timer_done && !m_prev;
        if (reset) begin
            m_alert = 1'b0;
            m_t = 0;
        end else if (ack) begin
            m_alert = 1'b0;
            m_t = 0;
        end else if (m_alert) begin
            if (m_t < TOTAL) m_t++;
        end else if (start) begin
            m_alert = 1'b1;
            m_t = 0;
        end
        m_prev = timer_done;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; timer_done = 1'b0; door_closed = 1'b1; clearn = 1'b1;
        tick(); tick();
        timer_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) reset = 1'b0;
            tick();
            vectors++;
            if (obs_vec() !== exp_vec() || obs_vec() !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%b exp=0000", i, obs_vec());
            end
        end
    endtask

    task automatic test_full_alert();
        int rises;
        logic last;
        timer_done = 1'b0; tick();
        timer_done = 1'b1;
        rises = 0; last = 1'b0;
        for (int i = 0; i <= TOTAL + 4; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL full_alert E%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (beep_active && !last) rises++;
            last = beep_active;
        end
        vectors++;
        if (rises != NBEEP) begin
            miscompares++;
            $display("FAIL beep_count got=%0d exp=%0d", rises, NBEEP);
        end
    endtask

    task automatic test_clear_restart();
        clearn = 1'b0; tick();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL clear_ack got=%b exp=%b", obs_vec(), exp_vec());
        end
        clearn = 1'b1; timer_done = 1'b0; tick();
        timer_done = 1'b1;
        for (int i = 0; i <= TOTAL + 2; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL restart E%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_door_abort();
        int k;
        door_closed = 1'b0; tick();
        door_closed = 1'b1; timer_done = 1'b0; tick();
        timer_done = 1'b1; tick();
        k = $urandom_range(PERIOD, PERIOD + ON_C - 1);
        while (m_t < k) tick();
        door_closed = 1'b0;
        tick();
        vectors++;
        if (obs_vec() !== 4'b0000 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL door_abort t=%0d got=%b exp=0000", k, obs_vec());
        end
        door_closed = 1'b1;
        for (int i = 0; i < TOTAL; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL after_abort cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_retrigger_ignored();
        int k;
        timer_done = 1'b0; tick();
        timer_done = 1'b1; tick();
        k = $urandom_range(ON_C, PERIOD - 2);
        while (m_t < k) tick();
        timer_done = 1'b0; tick();
        timer_done = 1'b1;
        while (m_t < TOTAL + 3 && m_alert) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL retrigger t=%0d got=%b exp=%b", m_t, obs_vec(), exp_vec());
            end
            if (m_t == TOTAL) break;
        end
        vectors++;
        if ({done_led, alarm_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL retrigger_latched got=%b exp=10", {done_led, alarm_busy});
        end
    endtask

    task automatic test_ack_at_start();
        clearn = 1'b0; tick();
        clearn = 1'b1; timer_done = 1'b0; tick();
        door_closed = 1'b0; timer_done = 1'b1;
        tick();
        vectors++;
        if (obs_vec() !== 4'b0000) begin
            miscompares++;
            $display("FAIL ack_at_start got=%b exp=0000", obs_vec());
        end
        door_closed = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL ack_at_start_hold cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            door_closed = ($urandom_range(0, 39) != 0);
            clearn      = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 9) == 0) timer_done = ~timer_done;
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            vectors++;
            if (buzzer && !beep_active) begin
                miscompares++;
                $display("FAIL buzzer_gate cyc=%0d buzzer=1 beep_active=0", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_alert();
        test_clear_restart();
        test_door_abort();
        test_retrigger_ignored();
        test_ack_at_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
